spike_router_core: RTL



---
 rtl/spike_router_core.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/spike_router_core.sv
// Spike router: ingress FIFO dispatches one packet per cycle; a strobe lands two cycles after in_valid is presented.
// Egress emits a spike's fanout packets round-robin, held stable while out_ready is low; ingress stalls only when the FIFO is full.
module spike_router_core #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int FIFO_DEPTH  = 8,
    parameter int MAX_FANOUT  = 4,
    localparam int CNT_W      = $clog2(MAX_FANOUT + 1),
    localparam int IDX_W      = $clog2(NUM_NEURONS)
) (
    input  logic                                     CLK,
    input  logic                                     clear,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [2*ADDR_W-1:0]                      in_packet,
    input  logic [NUM_NEURONS*ADDR_W-1:0]            neuron_addresses,
    output logic [NUM_NEURONS*ADDR_W-1:0]            source_addresses,
    output logic [NUM_NEURONS-1:0]                   src_strobe,
    input  logic [NUM_NEURONS-1:0]                   spike,
    input  logic [NUM_NEURONS*MAX_FANOUT*ADDR_W-1:0] conn_table,
    input  logic [NUM_NEURONS*CNT_W-1:0]             conn_count,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [2*ADDR_W-1:0]                      out_packet,
    output logic [15:0]                              unmatched_cnt,
    output logic [15:0]                              coalesced_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, EMIT} egress_state_t;

    logic [2*ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, push, pop;
    logic [2*ADDR_W-1:0] head;
    logic                match_hit;
    logic [IDX_W-1:0]    match_idx;

    egress_state_t           state, state_nxt;
    logic [NUM_NEURONS-1:0]  pending, clr;
    logic [IDX_W-1:0]        rr_ptr, rr_nxt, cur_k, k_nxt, sel_k;
    logic [CNT_W-1:0]        cur_j, j_nxt, cur_eff, eff_nxt, sel_cnt, sel_eff;
    logic                    sel_hit, valid_nxt;
    logic [2*ADDR_W-1:0]     pkt_nxt;
    logic [6:0]              coal_n;
    logic [16:0]             coal_sum;

    // Ingress FIFO: the extra pointer bit separates full from empty
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign pop        = !fifo_empty;
    assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= in_packet;
        end
    end

    // Descending scan so the lowest matching neuron wins
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (neuron_addresses[i*ADDR_W +: ADDR_W] == head[ADDR_W-1:0]) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            src_strobe       <= '0;
            source_addresses <= '0;
            unmatched_cnt    <= '0;
        end else begin
            src_strobe <= '0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (match_hit) begin
                    src_strobe[match_idx]                             <= 1'b1;
                    source_addresses[int'(match_idx)*ADDR_W +: ADDR_W] <= head[2*ADDR_W-1:ADDR_W];
                end else if (unmatched_cnt != 16'hFFFF) begin
                    unmatched_cnt <= unmatched_cnt + 16'd1;
                end
            end
        end
    end

    // Round-robin pick: descending offsets leave the nearest set bit from rr_ptr
    always_comb begin
        sel_hit = 1'b0;
        sel_k   = '0;
        for (int off = NUM_NEURONS - 1; off >= 0; off--) begin
            if (pending[(int'(rr_ptr) + off) % NUM_NEURONS]) begin
                sel_hit = 1'b1;
                sel_k   = IDX_W'((int'(rr_ptr) + off) % NUM_NEURONS);
            end
        end
    end

    assign sel_cnt = conn_count[int'(sel_k)*CNT_W +: CNT_W];
    assign sel_eff = (sel_cnt > CNT_W'(MAX_FANOUT)) ? CNT_W'(MAX_FANOUT) : sel_cnt;

    function automatic logic [IDX_W-1:0] wrap_next(input logic [IDX_W-1:0] k);
        return (int'(k) == NUM_NEURONS - 1) ? '0 : k + 1'b1;
    endfunction

    function automatic logic [2*ADDR_W-1:0] fan_pkt(input logic [IDX_W-1:0] k,
                                                    input logic [CNT_W-1:0] j);
        return {neuron_addresses[int'(k)*ADDR_W +: ADDR_W],
                conn_table[(int'(k)*MAX_FANOUT + int'(j))*ADDR_W +: ADDR_W]};
    endfunction

    always_comb begin
        state_nxt = state;
        k_nxt     = cur_k;
        j_nxt     = cur_j;
        eff_nxt   = cur_eff;
        rr_nxt    = rr_ptr;
        valid_nxt = out_valid;
        pkt_nxt   = out_packet;
        clr       = '0;
        case (state)
            IDLE: begin
                if (sel_hit) begin
                    clr[sel_k] = 1'b1;
                    k_nxt      = sel_k;
                    j_nxt      = '0;
                    eff_nxt    = sel_eff;
                    if (sel_cnt == '0) begin
                        rr_nxt = wrap_next(sel_k);
                    end else begin
                        state_nxt = EMIT;
                        valid_nxt = 1'b1;
                        pkt_nxt   = fan_pkt(sel_k, '0);
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (cur_j == cur_eff - 1'b1) begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                        rr_nxt    = wrap_next(cur_k);
                    end else begin
                        j_nxt   = cur_j + 1'b1;
                        pkt_nxt = fan_pkt(cur_k, cur_j + 1'b1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A spike landing on a bit that stays pending is merged and counted
    always_comb begin
        coal_n = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            coal_n = coal_n + {6'b0, spike[i] & pending[i] & ~clr[i]};
        end
        coal_sum = {1'b0, coalesced_cnt} + {10'b0, coal_n};
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            state         <= IDLE;
            pending       <= '0;
            rr_ptr        <= '0;
            cur_k         <= '0;
            cur_j         <= '0;
            cur_eff       <= '0;
            out_valid     <= 1'b0;
            out_packet    <= '0;
            coalesced_cnt <= '0;
        end else begin
            state         <= state_nxt;
            pending       <= (pending & ~clr) | spike;
            rr_ptr        <= rr_nxt;
            cur_k         <= k_nxt;
            cur_j         <= j_nxt;
            cur_eff       <= eff_nxt;
            out_valid     <= valid_nxt;
            out_packet    <= pkt_nxt;
            coalesced_cnt <= coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
        end
    end
endmodule
